// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: FSM states, cause codes and
// the handler vector locations also used by exception_handler.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_RESTORE = 3'd4
  } state_t;

  localparam logic [1:0] EXC_OPCODE = 2'b00;
  localparam logic [1:0] EXC_OVF    = 2'b01;
  localparam logic [1:0] EXC_DIV0   = 2'b10;

  localparam logic [31:0] VEC_OPCODE = 32'd253;
  localparam logic [31:0] VEC_OVF    = 32'd254;
  localparam logic [31:0] VEC_DIV0   = 32'd255;

  // Fixed priority when several flags are raised together: opcode > ovf > div0.
  function automatic logic [1:0] pick_cause(input logic op, input logic ovf);
    if (op)       return EXC_OPCODE;
    else if (ovf) return EXC_OVF;
    else          return EXC_DIV0;
  endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Loadable down-counter with a zero flag; times the memory wait in FETCH.
module exc_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception entry / return-from-exception sequencer.
// Optional status outputs (cause_q, exc_count) are built when EXC_STATUS_EN is defined.
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int          MEM_WAIT   = 2,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        rte_req,
  input  logic [31:0] old_pc,
  input  logic [31:0] vec_addr,
  input  logic [7:0]  mem_byte,
  output logic [1:0]  ec_control,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        busy
`ifdef EXC_STATUS_EN
  ,
  output logic [1:0]  cause_q,
  output logic [7:0]  exc_count
`endif
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT - 1);

  state_t      state_q;
  logic [1:0]  cur_cause_q;
  logic [31:0] epc_q;
  logic [7:0]  vec_q;
  logic        wait_zero;
  logic        any_exc;

  assign any_exc = exc_opcode | exc_ovf | exc_div0;

  exc_wait_counter #(.W(CW)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == ST_SAVE),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ST_FETCH),
    .zero_o     (wait_zero)
  );

  // Requests are only looked at in IDLE; anything arriving while busy is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_cause_q <= EXC_OPCODE;
      epc_q       <= '0;
      vec_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_exc) begin
            cur_cause_q <= pick_cause(exc_opcode, exc_ovf);
            state_q     <= ST_SAVE;
          end else if (rte_req) begin
            state_q <= ST_RESTORE;
          end
        end
        ST_SAVE: begin
          epc_q   <= old_pc - EPC_OFFSET;
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (wait_zero) begin
            vec_q   <= mem_byte;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD:    state_q <= ST_IDLE;
        ST_RESTORE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef EXC_STATUS_EN
  logic [7:0] exc_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count_q <= '0;
    end else if ((state_q == ST_IDLE) && any_exc && (exc_count_q != 8'hFF)) begin
      exc_count_q <= exc_count_q + 8'd1;
    end
  end

  assign cause_q   = cur_cause_q;
  assign exc_count = exc_count_q;
`endif

  always_comb begin
    ec_control = 2'b00;
    mem_read   = 1'b0;
    mem_addr   = '0;
    epc_write  = 1'b0;
    epc_data   = '0;
    pc_write   = 1'b0;
    pc_next    = '0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_SAVE: begin
        ec_control = cur_cause_q;
        epc_write  = 1'b1;
        epc_data   = old_pc - EPC_OFFSET;
      end
      ST_FETCH: begin
        ec_control = cur_cause_q;
        mem_read   = 1'b1;
        mem_addr   = vec_addr;
      end
      ST_LOAD: begin
        ec_control = cur_cause_q;
        pc_write   = 1'b1;
        pc_next    = {24'b0, vec_q};
      end
      ST_RESTORE: begin
        pc_write = 1'b1;
        pc_next  = epc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: stimulus table, hand-written
// corner sequences and a randomised entry loop, all checked through exp_q.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0, rte_req;
  logic [31:0] old_pc, vec_addr;
  logic [7:0]  mem_byte;
  logic [1:0]  ec_control;
  logic        mem_read, epc_write, pc_write, busy;
  logic [31:0] mem_addr, epc_data, pc_next;
`ifdef EXC_STATUS_EN
  logic [1:0]  cause_q;
  logic [7:0]  exc_count;
`endif

  exception_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .rte_req    (rte_req),
    .old_pc     (old_pc),
    .vec_addr   (vec_addr),
    .mem_byte   (mem_byte),
    .ec_control (ec_control),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .epc_write  (epc_write),
    .epc_data   (epc_data),
    .pc_write   (pc_write),
    .pc_next    (pc_next),
    .busy       (busy)
`ifdef EXC_STATUS_EN
    ,
    .cause_q    (cause_q),
    .exc_count  (exc_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         op, ovf, div0, rte;
    logic [31:0]  pc, va;
    logic [7:0]   mb;
    logic [101:0] exp;
  } vec_t;

  logic [101:0] exp_q[$];
  vec_t         tbl[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  last_epc;

  function automatic logic [101:0] eo(input logic [1:0] ec, input logic rd,
                                      input logic [31:0] ma, input logic ew,
                                      input logic [31:0] ed, input logic pw,
                                      input logic [31:0] pn, input logic bz);
    return {ec, rd, ma, ew, ed, pw, pn, bz};
  endfunction

  function automatic logic [101:0] dut_out();
    return {ec_control, mem_read, mem_addr, epc_write, epc_data, pc_write, pc_next, busy};
  endfunction

  function automatic vec_t mk(input logic op, input logic ovf, input logic div0,
                              input logic rte, input logic [31:0] pc,
                              input logic [31:0] va, input logic [7:0] mb,
                              input logic [101:0] e);
    vec_t v;
    v.op = op; v.ovf = ovf; v.div0 = div0; v.rte = rte;
    v.pc = pc; v.va = va; v.mb = mb; v.exp = e;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [101:0] act);
    logic [101:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h but no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // driver
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    exc_opcode = v.op; exc_ovf = v.ovf; exc_div0 = v.div0; rte_req = v.rte;
    old_pc = v.pc; vec_addr = v.va; mem_byte = v.mb;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name, dut_out());
  endtask

  // One full entry; hold keeps the flags up throughout, inject pulses div0+rte while busy.
  task automatic do_entry(input string name, input logic op, input logic ovf,
                          input logic div0, input logic [31:0] pc,
                          input logic [7:0] mb, input logic hold, input logic inject);
    logic [1:0]  c;
    logic [31:0] va;
    logic        hop, hovf, hdiv;
    c    = op ? 2'd0 : (ovf ? 2'd1 : 2'd2);
    va   = 32'd253 + {30'd0, c};
    hop  = hold & op;
    hovf = hold & ovf;
    hdiv = (hold & div0) | inject;
    step({name, "_save"}, mk(op, ovf, div0, 1'b0, pc, va, mb,
                             eo(c, 1'b0, 32'd0, 1'b1, pc - 32'd4, 1'b0, 32'd0, 1'b1)));
    for (int k = 0; k < 2; k++)
      step({name, "_fetch"}, mk(hop, hovf, hdiv, inject, pc, va, mb,
                                eo(c, 1'b1, va, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    step({name, "_load"}, mk(hop, hovf, hdiv, inject, pc, va, mb,
                             eo(c, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, {24'd0, mb}, 1'b1)));
    step({name, "_idle"}, mk(hop, hovf, hold & div0, 1'b0, pc, va, mb, '0));
    last_epc = pc - 32'd4;
  endtask

  task automatic do_rte(input string name, input logic [31:0] epc);
    step({name, "_restore"}, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 8'd0,
                                eo(2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, epc, 1'b1)));
    step({name, "_idle"}, mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0, '0));
  endtask

  initial begin
    logic [101:0] z;
    z = '0;
    reset = 1'b1;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0; rte_req = 1'b0;
    old_pc = '0; vec_addr = '0; mem_byte = '0;

    // overflow entry, old_pc 0x40, vector byte 0x80, then return
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'd254, 8'h80, eo(2'd1, 1'b0, 32'd0, 1'b1, 32'h3C, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd254, 8'h80, eo(2'd1, 1'b1, 32'd254, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd254, 8'h80, eo(2'd1, 1'b1, 32'd254, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd254, 8'h80, eo(2'd1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd254, 8'h80, z));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0, 8'h00, eo(2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h3C, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 8'h00, z));
    // opcode + div0 together for one cycle: opcode wins, div0 never taken
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'd253, 8'h11, eo(2'd0, 1'b0, 32'd0, 1'b1, 32'hFC, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd253, 8'h11, eo(2'd0, 1'b1, 32'd253, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd253, 8'h11, eo(2'd0, 1'b1, 32'd253, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd253, 8'h11, eo(2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h11, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd253, 8'h11, z));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'd253, 8'h11, z));
    // div0 and rte at the same edge with old_pc 0: exception wins, EPC wraps
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'd255, 8'hFF, eo(2'd2, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd255, 8'hFF, eo(2'd2, 1'b1, 32'd255, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd255, 8'hFF, eo(2'd2, 1'b1, 32'd255, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd255, 8'hFF, eo(2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFF, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd255, 8'hFF, z));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0, 8'h00, eo(2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b1)));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 8'h00, z));

    // reset state, including an rte pulse while reset is held
    repeat (2) @(posedge clk);
    rte_req = 1'b1;
    #1;
    exp_q.push_back(z);
    check("reset_outputs", dut_out());
`ifdef EXC_STATUS_EN
    exp_q.push_back('0);
    check("reset_status", {92'd0, cause_q, exc_count});
`endif
    @(negedge clk);
    reset = 1'b0;
    rte_req = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl[%0d]", i), tbl[i]);

    // flags and rte pulsed during the entry are ignored; exactly one pc_write
    do_entry("busy_ignore", 1'b0, 1'b1, 1'b0, 32'h200, 8'h22, 1'b0, 1'b1);
    step("busy_ignore_quiet", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 8'h0, z));

    // flag held high: not seen on LOAD->IDLE edge, retriggers on the next one
    do_entry("held_a", 1'b0, 1'b0, 1'b1, 32'h1000, 8'h5A, 1'b1, 1'b0);
    do_entry("held_b", 1'b0, 1'b0, 1'b1, 32'h2000, 8'hA5, 1'b0, 1'b0);
    do_rte("held_rte", last_epc);

    for (int i = 0; i < 12; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(1, 7));
      do_entry($sformatf("rand[%0d]", i), f[2], f[1], f[0],
               $urandom_range(0, 32'h7FFFFFFF), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (f[0]) do_rte($sformatf("rand_rte[%0d]", i), last_epc);
    end

    // async reset in the middle of FETCH, then rte restores PC to 0
    step("rst_save", mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'd254, 8'h33,
                        eo(2'd1, 1'b0, 32'd0, 1'b1, 32'h2FC, 1'b0, 32'd0, 1'b1)));
    step("rst_fetch", mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'd254, 8'h33,
                         eo(2'd1, 1'b1, 32'd254, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1)));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(z);
    check("rst_mid_fetch", dut_out());
    @(negedge clk);
    reset = 1'b0;
    do_rte("rst_rte", 32'd0);

`ifdef EXC_STATUS_EN
    begin
      logic [1:0] last_c;
      last_c = 2'd0;
      for (int i = 0; i < 300; i++) begin
        int s;
        s = $urandom_range(0, 2);
        last_c = 2'(s);
        do_entry("status", s == 0, s == 1, s == 2, 32'h400, 8'h44, 1'b0, 1'b0);
      end
      exp_q.push_back({92'd0, last_c, 8'd255});
      check("status_saturate", {92'd0, cause_q, exc_count});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
